clk_step_sched: RTL and testbench
=================================

# clk_step_sched

Clock-enable scheduler for the FPGA RISC-V core. It replaces the free-running toggled slow clock with a single-cycle `tick` enable on the system clock. Run, halt, single-step and N-step burst execution are commanded over a valid/ready port, and the tick period is programmable. It sits between the board-level debug/button logic and the core's pipeline enable.

## Interface
Parameters:
- `DIV_W`, 24: width of the tick divisor.
- `DIV_DEFAULT`, 1_000_000: divisor loaded at reset, in system clocks per tick.
- `BURST_W`, 8: width of the burst step count.

Ports:
- `clk`  in  1  system clock; all logic on posedge.
- `rst_n`  in  1  reset; synchronous and active-low.
- `cmd_valid`  in  1  command offered.
- `cmd_ready`  out  1  command accepted when `cmd_valid && cmd_ready` at a posedge.
- `cmd_op`  in  2  command: 00 HALT, 01 RUN, 10 STEP, 11 BURST.
- `cmd_arg`  in  BURST_W  number of ticks for BURST; ignored for other ops.
- `halt_req`  in  1  abort; forces halt from any state.
- `div_valid`  in  1  load a new divisor this cycle.
- `div_val`  in  DIV_W  new divisor; 0 is treated as 1.
- `tick`  out  1  one-cycle core enable pulse.
- `busy`  out  1  STEP or BURST in progress.
- `mode`  out  2  current state encoding.
- `tick_cnt`  out  32  ticks issued since reset; present only with `CLK_SCHED_TICK_CNT_EN`.

## Operation
- States:
  - IDLE (00): no ticks.
  - RUN (01): periodic ticks.
  - STEP (10): exactly one tick, then IDLE.
  - BURST (11): `cmd_arg` ticks, then IDLE.
- Reset values: state IDLE, divisor `div_q` = DIV_DEFAULT, phase counter 0, burst remaining 0, `tick`=0, `busy`=0, `mode`=00, `tick_cnt`=0.
- Handshake: `cmd_ready = !busy && !halt_req`.
  - Commands are accepted in IDLE or RUN only.
  - A new command replaces RUN immediately.
- Accept transitions:
  - HALT goes to IDLE.
  - RUN goes to RUN.
  - STEP goes to STEP.
  - BURST goes to BURST with remaining = `cmd_arg`.
  - BURST with `cmd_arg`=0 is accepted and goes to IDLE with no tick.
- Phase counter:
  - Counts 0 to `div_q`-1 and wraps.
  - Restarts at 0 on every command accept and every divisor load.
  - In IDLE it is held at 0.
- `tick`: asserted in the cycle after the counter reaches `div_q`-1, but only while the state is RUN, STEP or BURST.
- STEP: the state stays STEP during its tick cycle, then becomes IDLE.
- BURST:
  - remaining decrements on each tick.
  - The tick that brings remaining to 0 is the last one; the next cycle is IDLE.
- `halt_req`:
  - Wins over a simultaneous `cmd_valid`; that command is not accepted.
  - Next state is IDLE, remaining cleared, counter cleared.
  - A tick pending in the same cycle is suppressed.
- `div_valid`:
  - `div_q` takes `max(div_val,1)` on the next cycle.
  - Allowed in any state.
  - If it coincides with a command accept, both apply and there is a single counter restart.
- Arithmetic: the counter is DIV_W bits. The compare is against `div_q`-1 computed in DIV_W bits, so `div_q` ≥ 1 guarantees no underflow.

## Timing
- Command accepted at edge T: state and `mode` update at T+1 (registered).
- With divisor D, ticks occur at cycles T+D, T+2D, …
  - D=1 in RUN gives a tick every cycle from T+1.
- STEP accepted at T:
  - Single tick at T+D.
  - `busy` is high from T+1 through T+D and low at T+D+1.
  - `cmd_ready` returns at T+D+1.
- `halt_req` sampled at edge H: IDLE, `busy`=0 and `tick`=0 from H+1.
- `rst_n` low during a burst: all registers return to reset values at the next edge, and remaining ticks are discarded.

## Configuration
- `CLK_SCHED_TICK_CNT_EN` defined:
  - 32-bit `tick_cnt` increments on every `tick` and wraps modulo 2^32.
  - Cleared only by reset.
- Macro undefined: the `tick_cnt` port and its counter are absent. All other behaviour is identical.

## Structure
- Shared package `clk_sched_pkg`:
  - op enum (HALT/RUN/STEP/BURST).
  - state enum (IDLE/RUN/STEP/BURST, encoding equal to `mode`).
  - `DIV_DEFAULT` constant.
- Sub-module `tick_div`: phase counter with `restart` input, `div_q` input and terminal-count output.
- The FSM and burst counter live in `clk_step_sched`.

## Test plan
- Reset, then RUN with D=4 accepted at T → `tick` at T+4, T+8, T+12; `mode`=01; `busy`=0 throughout.
- div=3, STEP at T → one tick at T+3; `busy` high T+1..T+3; `cmd_ready` low until T+4; a second `cmd_valid` held during STEP is accepted at T+4.
- div=2, BURST `cmd_arg`=3 at T → ticks at T+2, T+4, T+6; IDLE at T+7.
- BURST 10 with div=2, `halt_req` asserted after the 2nd tick → exactly 2 ticks; `mode`=00 next cycle; a simultaneous `cmd_valid` is not accepted.
- RUN with D=4, `div_valid` with `div_val`=0 mid-period → counter restarts; `tick` every cycle from the load+1 onward.
- With `CLK_SCHED_TICK_CNT_EN`: RUN D=1 for 100 cycles, then HALT → `tick_cnt`=100; reset → 0.

Source files
------------

// File: rtl/clk_sched_pkg.sv
// Shared types and constants for the clock-enable scheduler.
// Encodings of op_e and state_e are the values seen on cmd_op and mode.
package clk_sched_pkg;

    typedef enum logic [1:0] {
        OP_HALT  = 2'b00,
        OP_RUN   = 2'b01,
        OP_STEP  = 2'b10,
        OP_BURST = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_RUN   = 2'b01,
        ST_STEP  = 2'b10,
        ST_BURST = 2'b11
    } state_e;

    localparam int DIV_DEFAULT = 1_000_000;
    localparam int TICK_CNT_W  = 32;

endpackage

// File: rtl/clk_step_sched_tick_div.sv
// Phase counter for the tick scheduler: counts 0..div_q-1 and flags the
// terminal phase. restart treats the current cycle as phase 0; clear holds it at 0.
module tick_div
    import clk_sched_pkg::*;
#(
    parameter int DIV_W = 24
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             restart,
    input  logic [DIV_W-1:0] div_q,
    output logic             terminal
);

    logic [DIV_W-1:0] phase_q;
    logic [DIV_W-1:0] phase_d;
    logic [DIV_W-1:0] phase_eff;
    logic [DIV_W-1:0] phase_last;

    always_comb begin
        phase_last = div_q - DIV_W'(1);
        phase_eff  = restart ? '0 : phase_q;
        terminal   = !clear && (phase_eff == phase_last);
        if (clear || terminal) begin
            phase_d = '0;
        end else begin
            phase_d = phase_eff + DIV_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= '0;
        end else begin
            phase_q <= phase_d;
        end
    end

endmodule

// File: rtl/clk_step_sched.sv
// Run/halt/step/burst clock-enable scheduler producing a one-cycle tick.
// Define CLK_SCHED_TICK_CNT_EN to add the 32-bit tick_cnt output.
module clk_step_sched
    import clk_sched_pkg::*;
#(
    parameter int DIV_W       = 24,
    parameter int DIV_DEFAULT = clk_sched_pkg::DIV_DEFAULT,
    parameter int BURST_W     = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic [1:0]         cmd_op,
    input  logic [BURST_W-1:0] cmd_arg,
    input  logic               halt_req,
    input  logic               div_valid,
    input  logic [DIV_W-1:0]   div_val,
    output logic               tick,
    output logic               busy,
    output logic [1:0]         mode
`ifdef CLK_SCHED_TICK_CNT_EN
    ,
    output logic [31:0]        tick_cnt
`endif
);

    state_e             state_q;
    state_e             state_d;
    logic [BURST_W-1:0] rem_q;
    logic [BURST_W-1:0] rem_d;
    logic [DIV_W-1:0]   div_q;
    logic [DIV_W-1:0]   div_d;
    logic               tick_q;
    logic               accept;
    logic               div_restart;
    logic               div_clear;
    logic               div_terminal;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            rem_q   <= '0;
            div_q   <= DIV_W'(DIV_DEFAULT);
            tick_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            div_q   <= div_d;
            tick_q  <= div_terminal;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        div_d   = div_q;
        accept  = cmd_valid && cmd_ready;

        if (div_valid) begin
            div_d = (div_val == '0) ? DIV_W'(1) : div_val;
        end

        if (halt_req) begin
            state_d = ST_IDLE;
            rem_d   = '0;
        end else if (accept) begin
            unique case (op_e'(cmd_op))
                OP_HALT:  state_d = ST_IDLE;
                OP_RUN:   state_d = ST_RUN;
                OP_STEP:  state_d = ST_STEP;
                OP_BURST: begin
                    rem_d   = cmd_arg;
                    state_d = (cmd_arg == '0) ? ST_IDLE : ST_BURST;
                end
            endcase
        end else begin
            // tick_q is the tick being issued now; it ends STEP and counts down BURST
            case (state_q)
                ST_STEP: begin
                    if (tick_q) begin
                        state_d = ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (tick_q) begin
                        rem_d = rem_q - BURST_W'(1);
                        if (rem_q <= BURST_W'(1)) begin
                            state_d = ST_IDLE;
                        end
                    end
                end
                default: ;
            endcase
        end

        div_restart = accept || div_valid;
        div_clear   = (state_d == ST_IDLE);
    end

    // Output logic
    always_comb begin
        busy      = (state_q == ST_STEP) || (state_q == ST_BURST);
        cmd_ready = !busy && !halt_req;
        mode      = state_q;
        tick      = tick_q;
    end

    // The divider sees the divisor in force this cycle, so a load restarts on the new period
    tick_div #(
        .DIV_W(DIV_W)
    ) u_tick_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (div_clear),
        .restart  (div_restart),
        .div_q    (div_d),
        .terminal (div_terminal)
    );

`ifdef CLK_SCHED_TICK_CNT_EN
    logic [TICK_CNT_W-1:0] tick_cnt_q;
    logic [TICK_CNT_W-1:0] tick_cnt_d;

    // Counts ticks as they are issued, so it moves in step with tick
    always_comb begin
        tick_cnt_d = tick_cnt_q + TICK_CNT_W'(div_terminal);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tick_cnt_q <= '0;
        end else begin
            tick_cnt_q <= tick_cnt_d;
        end
    end

    assign tick_cnt = tick_cnt_q;
`else
    // Tick counter not built in this configuration.
`endif

endmodule

// File: tb/tb_clk_step_sched.sv
// Self-checking bench for clk_step_sched: cycle-level reference model plus
// directed scenarios with literal tick timing expectations.
module tb_clk_step_sched;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic        halt_req;
    logic        div_valid;
    logic [23:0] div_val;
    logic        tick;
    logic        busy;
    logic [1:0]  mode;
`ifdef CLK_SCHED_TICK_CNT_EN
    logic [31:0] tick_cnt;
`endif

    clk_step_sched #(
        .DIV_W      (24),
        .DIV_DEFAULT(5),
        .BURST_W    (8)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_op   (cmd_op),
        .cmd_arg  (cmd_arg),
        .halt_req (halt_req),
        .div_valid(div_valid),
        .div_val  (div_val),
        .tick     (tick),
        .busy     (busy),
        .mode     (mode)
`ifdef CLK_SCHED_TICK_CNT_EN
        ,
        .tick_cnt (tick_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int unsigned cyc = 0;
    bit m_valid = 0;
    int tick_log[$];

    // Reference model: ticks fall on multiples of the divisor counted from the
    // last restart cycle (anchor), while the mode is not IDLE.
    typedef struct {
        int          st;
        int unsigned dv;
        int unsigned anchor;
        int unsigned rem;
        bit          tk;
        bit [31:0]   cnt;
    } model_t;

    model_t m = '{st: 0, dv: 5, anchor: 0, rem: 0, tk: 0, cnt: 0};

    function automatic model_t model_step(model_t cur, int unsigned c, bit rst, bit hv,
                                          bit cv, int op, int unsigned arg,
                                          bit dvv, int unsigned dval);
        model_t nx;
        bit acc;
        nx = cur;
        if (!rst) begin
            nx.st = 0; nx.dv = 5; nx.rem = 0; nx.tk = 0; nx.cnt = 0; nx.anchor = c;
            return nx;
        end
        acc = cv && !hv && (cur.st == 0 || cur.st == 1);
        if (hv) begin
            nx.st = 0;
            nx.rem = 0;
        end else if (acc) begin
            nx.anchor = c;
            case (op)
                0: nx.st = 0;
                1: nx.st = 1;
                2: nx.st = 2;
                default: begin
                    nx.rem = arg;
                    nx.st = (arg == 0) ? 0 : 3;
                end
            endcase
        end else if (cur.tk && cur.st == 2) begin
            nx.st = 0;
        end else if (cur.tk && cur.st == 3) begin
            nx.rem = cur.rem - 1;
            if (nx.rem == 0) nx.st = 0;
        end
        if (dvv) begin
            nx.dv = (dval == 0) ? 1 : dval;
            nx.anchor = c;
        end
        nx.tk = (nx.st != 0) && (((c + 1) - nx.anchor) % nx.dv == 0);
        nx.cnt = cur.cnt + 32'(nx.tk);
        return nx;
    endfunction

    always @(posedge clk) begin
        m <= model_step(m, cyc, rst_n, halt_req, cmd_valid, int'(cmd_op), cmd_arg,
                        div_valid, div_val);
        if (!rst_n) m_valid <= 1'b1;
        cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_valid) begin
            check("tick", 32'(tick), 32'(m.tk));
            check("mode", 32'(mode), m.st);
            check("busy", 32'(busy), 32'(m.st >= 2));
            check("cmd_ready", 32'(cmd_ready), 32'(!(m.st >= 2) && !halt_req));
`ifdef CLK_SCHED_TICK_CNT_EN
            check("tick_cnt", tick_cnt, m.cnt);
`endif
            if (tick === 1'b1) tick_log.push_back(int'(cyc));
        end
    end

    function automatic int tl(input int i);
        return (i < tick_log.size()) ? tick_log[i] : -1000;
    endfunction

    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic cmd(input int op, input int arg, output int t);
        cmd_valid = 1'b1;
        cmd_op    = 2'(op);
        cmd_arg   = 8'(arg);
        t         = int'(cyc);
        $display("cmd op=%0d arg=%0d div_load=%0d cycle=%0d", op, arg, div_valid, t);
        clk1();
        cmd_valid = 1'b0;
        div_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog cycle=%0d actual=timeout expected=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        int acc_cyc;
        int n;
        rst_n = 1'b0; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_arg = 8'd0;
        halt_req = 1'b0; div_valid = 1'b0; div_val = 24'd0;
        clk1();
        check("rst_mode", 32'(mode), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_tick", 32'(tick), 0);
        check("rst_ready", 32'(cmd_ready), 1);
        rst_n = 1'b1;
        clk1();

        // RUN with the reset divisor (5)
        tick_log.delete();
        cmd(1, 0, t);
        repeat (15) clk1();
        check("a_ntick", tick_log.size(), 3);
        check("a_tick0", tl(0) - t, 5);
        check("a_tick2", tl(2) - t, 15);
        cmd(0, 0, t);
        clk1();

        // RUN with D=4 loaded alongside the command
        tick_log.delete();
        div_valid = 1'b1; div_val = 24'd4;
        cmd(1, 0, t);
        repeat (12) clk1();
        check("b_ntick", tick_log.size(), 3);
        check("b_tick0", tl(0) - t, 4);
        check("b_tick1", tl(1) - t, 8);
        check("b_tick2", tl(2) - t, 12);
        check("b_mode", 32'(mode), 1);
        cmd(0, 0, t);
        clk1();

        // STEP at D=3 with a second command held during the step
        div_valid = 1'b1; div_val = 24'd3;
        clk1();
        div_valid = 1'b0;
        tick_log.delete();
        cmd_valid = 1'b1; cmd_op = 2'd2; t = int'(cyc);
        $display("cmd op=2 arg=0 held cycle=%0d", t);
        clk1();
        cmd_op = 2'd0;
        check("c_busy", 32'(busy), 1);
        n = 0;
        while (!cmd_ready && n < 10) begin
            clk1();
            n++;
        end
        acc_cyc = int'(cyc);
        check("c_ready_cyc", acc_cyc - t, 4);
        clk1();
        cmd_valid = 1'b0;
        repeat (3) clk1();
        check("c_ntick", tick_log.size(), 1);
        check("c_tick0", tl(0) - t, 3);

        // BURST 3 at D=2
        tick_log.delete();
        div_valid = 1'b1; div_val = 24'd2;
        cmd(3, 3, t);
        repeat (8) clk1();
        check("d_ntick", tick_log.size(), 3);
        check("d_tick0", tl(0) - t, 2);
        check("d_tick2", tl(2) - t, 6);
        check("d_mode", 32'(mode), 0);

        // BURST 10 aborted after the 2nd tick, with a competing command
        tick_log.delete();
        cmd(3, 10, t);
        repeat (4) clk1();
        halt_req = 1'b1; cmd_valid = 1'b1; cmd_op = 2'd1;
        #1;
        check("f_ready_halt", 32'(cmd_ready), 0);
        clk1();
        halt_req = 1'b0; cmd_valid = 1'b0;
        check("f_mode", 32'(mode), 0);
        check("f_busy", 32'(busy), 0);
        repeat (4) clk1();
        check("f_ntick", tick_log.size(), 2);
        check("f_mode_late", 32'(mode), 0);

        // RUN at D=4, divisor 0 loaded mid-period
        tick_log.delete();
        div_valid = 1'b1; div_val = 24'd4;
        cmd(1, 0, t);
        repeat (5) clk1();
        div_valid = 1'b1; div_val = 24'd0;
        clk1();
        div_valid = 1'b0;
        repeat (4) clk1();
        check("g_ntick", tick_log.size(), 5);
        check("g_tick0", tl(0) - t, 4);
        check("g_tick1", tl(1) - t, 7);
        check("g_tick4", tl(4) - t, 10);
        cmd(0, 0, t);
        clk1();

        // BURST of zero length
        tick_log.delete();
        cmd(3, 0, t);
        check("h_mode", 32'(mode), 0);
        check("h_busy", 32'(busy), 0);
        repeat (3) clk1();
        check("h_ntick", tick_log.size(), 0);

        // Reset in the middle of a burst
        tick_log.delete();
        div_valid = 1'b1; div_val = 24'd2;
        cmd(3, 10, t);
        repeat (2) clk1();
        rst_n = 1'b0;
        clk1();
        rst_n = 1'b1;
        check("i_mode", 32'(mode), 0);
        check("i_busy", 32'(busy), 0);
        check("i_tick", 32'(tick), 0);
        repeat (5) clk1();
        check("i_ntick", tick_log.size(), 1);

`ifdef CLK_SCHED_TICK_CNT_EN
        rst_n = 1'b0;
        clk1();
        rst_n = 1'b1;
        div_valid = 1'b1; div_val = 24'd1;
        cmd(1, 0, t);
        repeat (99) clk1();
        cmd(0, 0, t);
        clk1();
        check("j_tick_cnt", tick_cnt, 100);
        rst_n = 1'b0;
        clk1();
        rst_n = 1'b1;
        check("j_tick_cnt_rst", tick_cnt, 0);
`endif

        repeat (2) clk1();
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
